// File: rtl/byte_unstriping_rx.sv
// byte_unstriping_rx
// Reassembles 4-lane striped words into a serial byte stream.
// Each cycle with any lane valid presents one word. Lane0 carries the
// earliest byte. Legal words contain 1..4 bytes and are contiguous from
// lane0. Legal words are buffered in a small FIFO together with their
// byte count. A two-state serializer then drains the FIFO one byte per
// cycle.
//
// Ports
//   clk                  rising-edge clock
//   reset                asynchronous active-low reset
//   data_in0..data_in3   striped lane bytes (WIDTH bits each)
//   valid_in0..valid_in3 per-lane valid bits
//   data_out             serial byte output, registered, 0 when not valid
//   valid_out            data_out carries a byte this cycle, registered
//   lane_err             one-cycle pulse: illegal lane pattern, word dropped
//   overflow             one-cycle pulse: FIFO full, word dropped
module byte_unstriping_rx #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             valid_in0,
  input  logic             valid_in1,
  input  logic             valid_in2,
  input  logic             valid_in3,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             lane_err,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // FIFO storage: 4 bytes per word plus the byte count.
  logic [3:0][WIDTH-1:0] mem_q     [FIFO_DEPTH];
  logic [2:0]            cnt_mem_q [FIFO_DEPTH];

  // Extra MSB distinguishes full from empty when the addresses match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  state_t           state_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_out_q;
  logic             lane_err_q;
  logic             overflow_q;

  logic [3:0]       pattern;
  logic             word_present;
  logic             legal;
  logic [2:0]       word_cnt;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic [2:0]       head_cnt;
  logic [WIDTH-1:0] head_byte;

  always_comb begin
    pattern      = {valid_in3, valid_in2, valid_in1, valid_in0};
    word_present = |pattern;
    legal        = 1'b1;
    word_cnt     = 3'd0;
    case (pattern)
      4'b0001: word_cnt = 3'd1;
      4'b0011: word_cnt = 3'd2;
      4'b0111: word_cnt = 3'd3;
      4'b1111: word_cnt = 3'd4;
      default: legal    = 1'b0;
    endcase

    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    head_cnt  = cnt_mem_q[rd_ptr_q[AW-1:0]];
    head_byte = mem_q[rd_ptr_q[AW-1:0]][idx_q];

    // The last byte of the head word is issued on this edge: release the slot.
    pop  = (state_q == SEND) && ({1'b0, idx_q} == head_cnt - 3'd1);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push = legal && (!full || pop);

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]]     <= {data_in3, data_in2, data_in1, data_in0};
      cnt_mem_q[wr_ptr_q[AW-1:0]] <= word_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      lane_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_err_q <= word_present && !legal;
      overflow_q <= legal && full && !pop;
      case (state_q)
        IDLE: begin
          valid_out_q <= 1'b0;
          data_out_q  <= '0;
          idx_q       <= '0;
          if (!empty) state_q <= SEND;
        end
        SEND: begin
          valid_out_q <= 1'b1;
          data_out_q  <= head_byte;
          if (pop) begin
            idx_q <= '0;
            // Staying in SEND when a word remains, including one pushed this
            // edge, gives back-to-back streaming with no bubble.
            state_q <= (wr_ptr_d != rd_ptr_d) ? SEND : IDLE;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_err  = lane_err_q;
  assign overflow  = overflow_q;

endmodule
